// File: rtl/roe_pkg.sv
// Shared types and constants for the roe_prog_core processor slice.
package roe_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_SLB   = 4'd1,
        OP_ADDI  = 4'd2,
        OP_SUBI  = 4'd3,
        OP_SLI   = 4'd4,
        OP_SRI   = 4'd5,
        OP_REDEF = 4'd6,
        OP_ADD   = 4'd7,
        OP_LD    = 4'd8,
        OP_SW    = 4'd9,
        OP_SLT   = 4'd10,
        OP_XOR   = 4'd11,
        OP_AND   = 4'd12,
        OP_OR    = 4'd13,
        OP_BR    = 4'd14,
        OP_HALT  = 4'd15
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int OP_MSB  = 9;
    localparam int OP_LSB  = 6;
    localparam int A_MSB   = 5;
    localparam int A_LSB   = 4;
    localparam int B_MSB   = 3;
    localparam int B_LSB   = 2;
    localparam int C_MSB   = 1;
    localparam int C_LSB   = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam int RF_DEPTH  = 8;
    localparam int DM_DEPTH  = 256;
    localparam int LUT_DEPTH = 16;

endpackage

// File: rtl/roe_prog_core_regfile.sv
// Banked 8x8 register file: three combinational reads, one synchronous write.
module roe_regfile
    import roe_pkg::*;
(
    input  logic       clk,
    input  logic       bank,
    input  logic [1:0] ra,
    input  logic [1:0] rb,
    input  logic [1:0] rc,
    input  logic       we,
    input  logic [7:0] wd,
    output logic [7:0] da,
    output logic [7:0] db,
    output logic [7:0] dc
);

    // No reset: contents must survive a core reset.
    logic [7:0] rf [0:RF_DEPTH-1];

    assign da = rf[{bank, ra}];
    assign db = rf[{bank, rb}];
    assign dc = rf[{bank, rc}];

    always_ff @(posedge clk) begin
        if (we)
            rf[{bank, ra}] <= wd;
    end

endmodule

// File: rtl/roe_prog_core.sv
// Single-cycle 8-bit R.O.E. core. Optional macro ROE_SIGNED_SLT_EN makes SLT a signed compare.
module roe_prog_core
    import roe_pkg::*;
#(
    parameter int IW        = 10,
    parameter int PCW       = 8,
    parameter     PROG_FILE = "prog.hex",
    parameter     LUT_FILE  = "lut.hex"
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic ack
);

    // ROM, LUT and DM are never reset; images are placed by the loader/backdoor.
    logic [IW-1:0]  rom [0:(2**PCW)-1];
    logic [PCW-1:0] lut [0:LUT_DEPTH-1];
    logic [7:0]     dm  [0:DM_DEPTH-1];

    logic [PCW-1:0] pc;
    state_t         state;
    logic           bank;

    logic [IW-1:0]  instr;
    opcode_t        op;
    logic [1:0]     fa, fb, fc;
    logic [3:0]     imm;
    logic [7:0]     va, vb, vc;
    logic [7:0]     wd;
    logic           rf_we, dm_we, taken, lt;

    assign instr = rom[pc];
    assign op    = opcode_t'(instr[OP_MSB:OP_LSB]);
    assign fa    = instr[A_MSB:A_LSB];
    assign fb    = instr[B_MSB:B_LSB];
    assign fc    = instr[C_MSB:C_LSB];
    assign imm   = instr[IMM_MSB:IMM_LSB];

    roe_regfile u_rf (
        .clk  (clk),
        .bank (bank),
        .ra   (fa),
        .rb   (fb),
        .rc   (fc),
        .we   (rf_we),
        .wd   (wd),
        .da   (va),
        .db   (vb),
        .dc   (vc)
    );

`ifdef ROE_SIGNED_SLT_EN
    assign lt = ($signed(vb) < $signed(vc));
`else
    assign lt = (vb < vc);
`endif

    always_comb begin
        wd    = '0;
        rf_we = 1'b0;
        dm_we = 1'b0;
        taken = 1'b0;
        if (state == RUN) begin
            case (op)
                OP_SLB:  begin wd = {va[7:4], imm};      rf_we = 1'b1; end
                OP_ADDI: begin wd = va + {4'h0, imm};    rf_we = 1'b1; end
                OP_SUBI: begin wd = va - {4'h0, imm};    rf_we = 1'b1; end
                OP_SLI:  begin wd = va << imm;           rf_we = 1'b1; end
                OP_SRI:  begin wd = va >> imm;           rf_we = 1'b1; end
                OP_ADD:  begin wd = vb + vc;             rf_we = 1'b1; end
                OP_LD:   begin wd = dm[vb];              rf_we = 1'b1; end
                OP_SW:   dm_we = 1'b1;
                OP_SLT:  begin wd = {7'b0, lt};          rf_we = 1'b1; end
                OP_XOR:  begin wd = vb ^ vc;             rf_we = 1'b1; end
                OP_AND:  begin wd = vb & vc;             rf_we = 1'b1; end
                OP_OR:   begin wd = vb | vc;             rf_we = 1'b1; end
                OP_BR:   taken = (vb != 8'h00);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (dm_we)
            dm[vb] <= va;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            state <= IDLE;
            bank  <= 1'b0;
            ack   <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req)
                        state <= RUN;
                end
                RUN: begin
                    pc <= taken ? lut[vc[3:0]] : pc + 1'b1;
                    if (op == OP_REDEF)
                        bank <= imm[0];
                    if (op == OP_HALT) begin
                        ack   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_roe_prog_core.sv
// Directed self-checking bench for roe_prog_core using backdoor ROM/LUT/RF/DM loads.
module tb_roe_prog_core;
    import roe_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic req   = 1'b0;
    logic ack;

    int tests  = 0;
    int failed = 0;

    roe_prog_core #(.IW(10), .PCW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .ack   (ack)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] enc(input int op, input int a, input int b, input int c);
        return {op[3:0], a[1:0], b[1:0], c[1:0]};
    endfunction

    function automatic logic [9:0] enci(input int op, input int a, input int imm);
        return {op[3:0], a[1:0], imm[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Fill ROM with HALT so any stray fetch terminates.
    task automatic clr_rom();
        for (int i = 0; i < 256; i++) dut.rom[i] = 10'h3C0;
    endtask

    task automatic run(output bit got, output int width);
        got   = 1'b0;
        width = 0;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (ack) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        while (ack && width < 4) begin
            width++;
            @(negedge clk);
        end
    endtask

    bit got;
    int width;
    int ack_seen;
    logic [7:0] slt_exp;

    initial begin
        // Reset state
        clr_rom();
        do_reset();
        chk("rst_pc", 32'(dut.pc), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_bank", 32'(dut.bank), 32'h0);

        // SLB
        dut.u_rf.rf[0] = 8'hAF;
        dut.rom[0] = enci(1, 0, 1);
        dut.rom[1] = enc(15, 0, 0, 0);
        run(got, width);
        chk("slb_ack", 32'(got), 32'h1);
        chk("slb_ackw", 32'(width), 32'h1);
        chk("slb_rf0", 32'(dut.u_rf.rf[0]), 32'hA1);
        chk("slb_pc", 32'(dut.pc), 32'h2);

        // ADDI / SUBI with restart at PC+1
        clr_rom();
        do_reset();
        dut.rom[0] = enci(2, 0, 8);
        dut.rom[1] = enc(15, 0, 0, 0);
        dut.rom[2] = enci(3, 0, 7);
        dut.rom[3] = enc(15, 0, 0, 0);
        dut.u_rf.rf[0] = 8'd100;
        run(got, width);
        chk("addi", 32'(dut.u_rf.rf[0]), 32'd108);
        dut.u_rf.rf[0] = 8'd100;
        run(got, width);
        chk("subi", 32'(dut.u_rf.rf[0]), 32'd93);
        chk("subi_pc", 32'(dut.pc), 32'h4);

        // Shifts, including shift amount >= 8, and a = a + a
        clr_rom();
        do_reset();
        dut.u_rf.rf[0] = 8'h02;
        dut.u_rf.rf[1] = 8'h10;
        dut.u_rf.rf[2] = 8'hFF;
        dut.u_rf.rf[3] = 8'h41;
        dut.rom[0] = enci(4, 0, 2);
        dut.rom[1] = enci(5, 1, 1);
        dut.rom[2] = enci(4, 2, 9);
        dut.rom[3] = enc(7, 3, 3, 3);
        dut.rom[4] = enc(15, 0, 0, 0);
        run(got, width);
        chk("sli", 32'(dut.u_rf.rf[0]), 32'h08);
        chk("sri", 32'(dut.u_rf.rf[1]), 32'h08);
        chk("sli9", 32'(dut.u_rf.rf[2]), 32'h00);
        chk("add_self", 32'(dut.u_rf.rf[3]), 32'h82);

        // Bank switching
        clr_rom();
        do_reset();
        dut.u_rf.rf[4] = 8'd99;
        dut.u_rf.rf[0] = 8'h11;
        dut.rom[0] = enci(6, 0, 1);
        dut.rom[1] = enci(2, 0, 2);
        dut.rom[2] = enci(6, 0, 0);
        dut.rom[3] = enc(15, 0, 0, 0);
        run(got, width);
        chk("bank_rf4", 32'(dut.u_rf.rf[4]), 32'd101);
        chk("bank_rf0", 32'(dut.u_rf.rf[0]), 32'h11);
        chk("bank_end", 32'(dut.bank), 32'h0);

        // LD then SW
        clr_rom();
        do_reset();
        dut.dm[0] = 8'hAD;
        dut.u_rf.rf[0] = 8'h00;
        dut.u_rf.rf[1] = 8'h00;
        dut.rom[0] = enc(8, 1, 0, 0);
        dut.rom[1] = enc(15, 0, 0, 0);
        run(got, width);
        chk("ld", 32'(dut.u_rf.rf[1]), 32'hAD);
        clr_rom();
        do_reset();
        dut.dm[1] = 8'h00;
        dut.u_rf.rf[0] = 8'h01;
        dut.u_rf.rf[1] = 8'hAA;
        dut.rom[0] = enc(9, 1, 0, 0);
        dut.rom[1] = enc(15, 0, 0, 0);
        run(got, width);
        chk("sw", 32'(dut.dm[1]), 32'hAA);
        chk("sw_rf1", 32'(dut.u_rf.rf[1]), 32'hAA);

        // SLT 5 < 1 -> 0
        clr_rom();
        do_reset();
        dut.u_rf.rf[0] = 8'd1;
        dut.u_rf.rf[1] = 8'd5;
        dut.u_rf.rf[2] = 8'h77;
        dut.rom[0] = enc(10, 2, 1, 0);
        dut.rom[1] = enc(15, 0, 0, 0);
        run(got, width);
        chk("slt5", 32'(dut.u_rf.rf[2]), 32'h0);

        // XOR / AND / OR with 0 and 1
        clr_rom();
        do_reset();
        dut.u_rf.rf[0] = 8'd1;
        dut.u_rf.rf[1] = 8'd0;
        dut.u_rf.rf[2] = 8'h00;
        dut.u_rf.rf[3] = 8'hFF;
        dut.rom[0] = enc(11, 2, 1, 0);
        dut.rom[1] = enc(12, 3, 1, 0);
        dut.rom[2] = enc(15, 0, 0, 0);
        dut.rom[3] = enc(13, 3, 1, 0);
        dut.rom[4] = enc(15, 0, 0, 0);
        run(got, width);
        chk("xor", 32'(dut.u_rf.rf[2]), 32'h1);
        chk("and", 32'(dut.u_rf.rf[3]), 32'h0);
        run(got, width);
        chk("or", 32'(dut.u_rf.rf[3]), 32'h1);

        // SLT 0x80 < 0x01: sign-dependent
`ifdef ROE_SIGNED_SLT_EN
        slt_exp = 8'h01;
`else
        slt_exp = 8'h00;
`endif
        clr_rom();
        do_reset();
        dut.u_rf.rf[0] = 8'h01;
        dut.u_rf.rf[1] = 8'h80;
        dut.u_rf.rf[2] = 8'h55;
        dut.rom[0] = enc(10, 2, 1, 0);
        dut.rom[1] = enc(15, 0, 0, 0);
        run(got, width);
        chk("slt80", 32'(dut.u_rf.rf[2]), 32'(slt_exp));

        // Branch taken skips ADDI; not taken executes it
        clr_rom();
        do_reset();
        dut.lut[0] = 8'd2;
        dut.u_rf.rf[0] = 8'd1;
        dut.u_rf.rf[1] = 8'd0;
        dut.u_rf.rf[2] = 8'd0;
        dut.rom[0] = enc(14, 0, 0, 1);
        dut.rom[1] = enci(2, 2, 1);
        dut.rom[2] = enc(15, 0, 0, 0);
        run(got, width);
        chk("br_taken", 32'(dut.u_rf.rf[2]), 32'h0);
        chk("br_pc", 32'(dut.pc), 32'h3);
        do_reset();
        dut.u_rf.rf[0] = 8'd0;
        run(got, width);
        chk("br_not", 32'(dut.u_rf.rf[2]), 32'h1);

        // Reset mid-RUN on a self-loop
        clr_rom();
        do_reset();
        dut.lut[0] = 8'd0;
        dut.u_rf.rf[0] = 8'd1;
        dut.u_rf.rf[1] = 8'd0;
        dut.u_rf.rf[3] = 8'h5A;
        dut.rom[0] = enc(14, 0, 0, 1);
        ack_seen = 0;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ack) ack_seen++;
            @(negedge clk);
        end
        chk("loop_state", 32'(dut.state), 32'(RUN));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(dut.pc), 32'h0);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (ack) ack_seen++;
            @(negedge clk);
        end
        chk("mid_rst_noack", 32'(ack_seen), 32'h0);
        chk("mid_rst_idle_pc", 32'(dut.pc), 32'h0);
        chk("mid_rst_rf3", 32'(dut.u_rf.rf[3]), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
